input_checker: RTL and testbench

INPUT_CHECKER -- requirements
Module: input_checker

---
 rtl/input_checker.sv | 150 +++++++++++++++
 tb/tb_input_checker.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_checker.sv
// input_checker: checks player button presses against the sequence generator for one round.
// Define INPUT_TIMEOUT_EN to build the WAIT-state idle timeout (limit set by TIMEOUT_CYCLES).
module input_checker #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] round_len,
  input  logic       btn_valid,
  input  logic [1:0] btn,
  input  logic [1:0] random,
  output logic       prng_step,
  output logic       prng_rerun,
  output logic       busy,
  output logic [4:0] press_count,
  output logic       pass,
  output logic       fail,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REWIND,
    S_SETTLE,
    S_WAIT,
    S_ADVANCE,
    S_PASS,
    S_FAIL
  } state_t;

  state_t     state;
  logic [4:0] len_q;
  logic [4:0] count_next;
  logic       press_hit;
  logic       last_press;

  // press_count cannot overflow: the round ends as soon as it reaches len_q (at most 31).
  assign count_next = press_count + 5'd1;
  assign press_hit  = (btn == random);
  assign last_press = (count_next == len_q);

`ifdef INPUT_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        limit_hit;
  logic        timeout_q;

  assign limit_hit = (({1'b0, idle_cnt} + 17'd1) == {1'b0, TIMEOUT_CYCLES});
  assign timeout   = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // All outputs are registered and set on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      press_count <= '0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      prng_step   <= 1'b0;
      prng_rerun  <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      pass       <= 1'b0;
      fail       <= 1'b0;
      prng_step  <= 1'b0;
      prng_rerun <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start && (round_len != 5'd0)) begin
            state       <= S_REWIND;
            len_q       <= round_len;
            press_count <= '0;
            busy        <= 1'b1;
            prng_rerun  <= 1'b1;
          end
        end
        S_REWIND: begin
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          state <= S_WAIT;
`ifdef INPUT_TIMEOUT_EN
          idle_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // A press on the limit cycle wins over the timeout.
          if (btn_valid) begin
            if (!press_hit) begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end else begin
              press_count <= count_next;
              if (last_press) begin
                state <= S_PASS;
                pass  <= 1'b1;
              end else begin
                state     <= S_ADVANCE;
                prng_step <= 1'b1;
              end
            end
          end
`ifdef INPUT_TIMEOUT_EN
          else if (limit_hit) begin
            state     <= S_FAIL;
            fail      <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
`endif
        end
        S_ADVANCE: begin
          state <= S_SETTLE;
        end
        S_PASS, S_FAIL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the registered outputs.
  a_pulses_exclusive: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({pass, fail, prng_step, prng_rerun}));
  a_timeout_with_fail: assert property (@(posedge clk) disable iff (!reset)
    timeout |-> fail);
  a_busy_tracks_state: assert property (@(posedge clk) disable iff (!reset)
    busy == (state != S_IDLE));
  a_count_bounded: assert property (@(posedge clk) disable iff (!reset)
    press_count <= len_q);
  a_timeout_cfg: assert property (@(posedge clk) disable iff (!reset)
    TIMEOUT_CYCLES != 16'd0);

endmodule

// File: tb/tb_input_checker.sv
// tb_input_checker: scoreboard bench for input_checker with a behavioural sequence generator;
// covers round outcomes, pulse counts, ignored inputs, async reset and the idle timeout.
module tb_input_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] round_len;
  logic       btn_valid;
  logic [1:0] btn;
  logic [1:0] random;
  logic       prng_step;
  logic       prng_rerun;
  logic       busy;
  logic [4:0] press_count;
  logic       pass;
  logic       fail;
  logic       timeout;

  typedef struct packed {
    logic       pass;
    logic       fail;
    logic       timeout;
    logic [4:0] pc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rerun_cnt   = 0;
  int   step_cnt    = 0;
  int   pass_cnt    = 0;
  int   fail_cnt    = 0;
  int   excl_cnt    = 0;

  logic [1:0] gen_seq [32];
  logic [4:0] gen_idx;

  input_checker #(.TIMEOUT_CYCLES(16'd10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .round_len   (round_len),
    .btn_valid   (btn_valid),
    .btn         (btn),
    .random      (random),
    .prng_step   (prng_step),
    .prng_rerun  (prng_rerun),
    .busy        (busy),
    .press_count (press_count),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural sequence generator driven by the checker's rerun/step pulses.
  always @(posedge clk or negedge reset) begin
    if (!reset)          gen_idx <= '0;
    else if (prng_rerun) gen_idx <= '0;
    else if (prng_step)  gen_idx <= gen_idx + 5'd1;
  end
  assign random = gen_seq[gen_idx];

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      rerun_cnt += int'(prng_rerun);
      step_cnt  += int'(prng_step);
      pass_cnt  += int'(pass);
      fail_cnt  += int'(fail);
      if ((int'(pass) + int'(fail) + int'(prng_step) + int'(prng_rerun)) > 1) excl_cnt++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic p, input logic f, input logic t, input logic [4:0] pc);
    mk = {p, f, t, pc};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [4:0] len);
    start     = 1'b1;
    round_len = len;
    tick;
    start     = 1'b0;
  endtask

  // Two edges from REWIND or ADVANCE land in WAIT; optional junk presses on both edges.
  task automatic to_wait(input bit junk, input logic [1:0] jc);
    btn_valid = junk;
    btn       = jc;
    tick;
    tick;
    btn_valid = 1'b0;
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid = 1'b1;
    btn       = c;
    tick;
    btn_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pass || fail) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL %s_result: got no pass/fail pulse in 40 cycles, want one", name);
    end else if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s_result: got pass=%b fail=%b, want no pulse", name, pass, fail);
    end else begin
      e = sb.pop_front();
      if ({pass, fail, timeout, press_count} !== e) begin
        miscompares++;
        $display("[TB] FAIL %s_result: got pass/fail/timeout/count=%b, want %b",
                 name, {pass, fail, timeout, press_count}, e);
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn       = 2'd0;
    round_len = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, pass, fail, timeout, prng_step, prng_rerun} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b want 000000",
               {busy, pass, fail, timeout, prng_step, prng_rerun});
    end
    vectors++;
    if (press_count !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_count: got %0d want 0", press_count);
    end
    start     = 1'b1;
    round_len = 5'd5;
    tick;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold_busy: got %b want 0", busy);
    end
    start = 1'b0;
    reset = 1'b1;
    tick;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single;
    int r0, s0;
    r0 = rerun_cnt;
    s0 = step_cnt;
    start_round(5'd1);
    to_wait(1'b0, 2'd0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'd1));
    press(gen_seq[0]);
    wait_result("single");
    tick;
    vectors++;
    if ((rerun_cnt - r0) != 1 || (step_cnt - s0) != 0) begin
      miscompares++;
      $display("[TB] FAIL single_pulses: got rerun=%0d step=%0d want rerun=1 step=0",
               rerun_cnt - r0, step_cnt - s0);
    end
    vectors++;
    if (press_count !== 5'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_idle: got count=%0d busy=%b want count=1 busy=0", press_count, busy);
    end
  endtask

  task automatic test_three;
    int r0, s0;
    r0 = rerun_cnt;
    s0 = step_cnt;
    start_round(5'd3);
    round_len = 5'd1;
    to_wait(1'b0, 2'd0);
    press(gen_seq[0]);
    to_wait(1'b0, 2'd0);
    press(gen_seq[1]);
    to_wait(1'b0, 2'd0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'd3));
    press(gen_seq[2]);
    wait_result("three");
    tick;
    vectors++;
    if ((rerun_cnt - r0) != 1 || (step_cnt - s0) != 2) begin
      miscompares++;
      $display("[TB] FAIL three_pulses: got rerun=%0d step=%0d want rerun=1 step=2",
               rerun_cnt - r0, step_cnt - s0);
    end
    vectors++;
    if (press_count !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL three_count: got %0d want 3", press_count);
    end
  endtask

  task automatic test_wrong;
    int s0;
    s0 = step_cnt;
    start_round(5'd4);
    to_wait(1'b0, 2'd0);
    press(gen_seq[0]);
    to_wait(1'b0, 2'd0);
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 5'd1));
    press(gen_seq[1] ^ 2'b01);
    wait_result("wrong");
    repeat (4) tick;
    vectors++;
    if ((step_cnt - s0) != 1) begin
      miscompares++;
      $display("[TB] FAIL wrong_steps: got %0d want 1", step_cnt - s0);
    end
    vectors++;
    if (press_count !== 5'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrong_hold: got count=%0d busy=%b want count=1 busy=0", press_count, busy);
    end
  endtask

  task automatic test_ignored;
    int r0, s0, p0, f0;
    r0 = rerun_cnt;
    s0 = step_cnt;
    p0 = pass_cnt;
    f0 = fail_cnt;
    start     = 1'b1;
    round_len = 5'd0;
    repeat (3) tick;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || (rerun_cnt - r0) != 0) begin
      miscompares++;
      $display("[TB] FAIL zero_len: got busy=%b rerun=%0d want busy=0 rerun=0", busy, rerun_cnt - r0);
    end
    btn_valid = 1'b1;
    btn       = 2'd2;
    repeat (2) tick;
    btn_valid = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b0 || (pass_cnt - p0) != 0 || (fail_cnt - f0) != 0) begin
      miscompares++;
      $display("[TB] FAIL idle_press: got busy=%b pass=%0d fail=%0d want 0 0 0",
               busy, pass_cnt - p0, fail_cnt - f0);
    end
    start     = 1'b1;
    round_len = 5'd2;
    tick;
    round_len = 5'd0;
    to_wait(1'b1, gen_seq[0] ^ 2'b10);
    press(gen_seq[0]);
    to_wait(1'b1, gen_seq[1] ^ 2'b11);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'd2));
    press(gen_seq[1]);
    start = 1'b0;
    wait_result("ignored");
    tick;
    vectors++;
    if ((rerun_cnt - r0) != 1 || (step_cnt - s0) != 1) begin
      miscompares++;
      $display("[TB] FAIL ignored_pulses: got rerun=%0d step=%0d want rerun=1 step=1",
               rerun_cnt - r0, step_cnt - s0);
    end
  endtask

  task automatic test_reset_mid;
    int p0, f0, r0;
    start_round(5'd4);
    to_wait(1'b0, 2'd0);
    press(gen_seq[0]);
    to_wait(1'b0, 2'd0);
    press(gen_seq[1]);
    to_wait(1'b0, 2'd0);
    p0 = pass_cnt;
    f0 = fail_cnt;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, pass, fail, timeout, prng_step, prng_rerun} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_flags: got %b want 000000",
               {busy, pass, fail, timeout, prng_step, prng_rerun});
    end
    vectors++;
    if (press_count !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_count: got %0d want 0", press_count);
    end
    repeat (2) tick;
    reset = 1'b1;
    repeat (3) tick;
    vectors++;
    if ((pass_cnt - p0) != 0 || (fail_cnt - f0) != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_quiet: got pass=%0d fail=%0d busy=%b want 0 0 0",
               pass_cnt - p0, fail_cnt - f0, busy);
    end
    r0 = rerun_cnt;
    start_round(5'd2);
    to_wait(1'b0, 2'd0);
    press(gen_seq[0]);
    to_wait(1'b0, 2'd0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'd2));
    press(gen_seq[1]);
    wait_result("after_reset");
    tick;
    vectors++;
    if ((rerun_cnt - r0) != 1) begin
      miscompares++;
      $display("[TB] FAIL after_reset_rerun: got %0d want 1", rerun_cnt - r0);
    end
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = rerun_cnt;
    start_round(5'd1);
    to_wait(1'b0, 2'd0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'd1));
    press(gen_seq[0]);
    start     = 1'b1;
    round_len = 5'd2;
    wait_result("b2b_first");
    tick;
    tick;
    start = 1'b0;
    to_wait(1'b0, 2'd0);
    vectors++;
    if (press_count !== 5'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_restart: got count=%0d busy=%b want count=0 busy=1", press_count, busy);
    end
    press(gen_seq[0]);
    to_wait(1'b0, 2'd0);
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'd2));
    press(gen_seq[1]);
    wait_result("b2b_second");
    tick;
    vectors++;
    if ((rerun_cnt - r0) != 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_rerun: got %0d want 2", rerun_cnt - r0);
    end
  endtask

  task automatic test_timeout;
    int f0;
`ifdef INPUT_TIMEOUT_EN
    f0 = fail_cnt;
    start_round(5'd1);
    to_wait(1'b0, 2'd0);
    repeat (9) tick;
    vectors++;
    if ((fail_cnt - f0) != 0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_early: got fail=%0d busy=%b want 0 1", fail_cnt - f0, busy);
    end
    sb.push_back(mk(1'b0, 1'b1, 1'b1, 5'd0));
    tick;
    wait_result("timeout");
    tick;
    start_round(5'd1);
    to_wait(1'b0, 2'd0);
    repeat (9) tick;
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'd1));
    press(gen_seq[0]);
    wait_result("timeout_priority");
    tick;
    f0 = fail_cnt;
    start_round(5'd2);
    to_wait(1'b0, 2'd0);
    repeat (7) tick;
    press(gen_seq[0]);
    to_wait(1'b0, 2'd0);
    repeat (9) tick;
    vectors++;
    if ((fail_cnt - f0) != 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_reload: got fail=%0d want 0", fail_cnt - f0);
    end
    sb.push_back(mk(1'b0, 1'b1, 1'b1, 5'd1));
    tick;
    wait_result("timeout_second");
    tick;
`else
    f0 = fail_cnt;
    start_round(5'd1);
    to_wait(1'b0, 2'd0);
    repeat (1000) tick;
    vectors++;
    if ((fail_cnt - f0) != 0 || busy !== 1'b1 || timeout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL no_timeout: got fail=%0d busy=%b timeout=%b want 0 1 0",
               fail_cnt - f0, busy, timeout);
    end
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 5'd1));
    press(gen_seq[0]);
    wait_result("no_timeout_pass");
    tick;
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gen_seq[i] = 2'($urandom_range(0, 3));
    test_reset;
    test_single;
    test_three;
    test_wrong;
    test_ignored;
    test_reset_mid;
    test_back_to_back;
    test_timeout;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    vectors++;
    if (excl_cnt != 0) begin
      miscompares++;
      $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles want 0", excl_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
